// File: rtl/frame_receiver.sv
// frame_receiver: decodes a pulse-width-coded serial LED data line into W-bit
// frames. The length of each high pulse selects the bit value. A long low
// period latches the frame set and resets the frame indexing.
module frame_receiver #(
  parameter int W        = 24,
  parameter int NUM_LEDS = 8,
  parameter int T_MIN    = 5,
  parameter int T_THRESH = 30,
  parameter int T_MAX    = 75,
  parameter int T_RESET  = 2500
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         din,
  output logic [W-1:0] frame_data,
  output logic         frame_valid,
  output logic [2:0]   frame_index,
  output logic         set_done,
  output logic         latch,
  output logic         bit_error
);

  localparam int MAXC = ((T_MAX + 1) > T_RESET) ? (T_MAX + 1) : T_RESET;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int BW   = (W > 1) ? $clog2(W) : 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [BW-1:0] bcnt_t;

  localparam cnt_t  T_MIN_C    = cnt_t'(T_MIN);
  localparam cnt_t  T_THRESH_C = cnt_t'(T_THRESH);
  localparam cnt_t  T_MAX_C    = cnt_t'(T_MAX);
  localparam cnt_t  T_SAT_C    = cnt_t'(T_MAX + 1);
  localparam cnt_t  T_RESET_C  = cnt_t'(T_RESET);
  localparam cnt_t  T_LATCH_C  = cnt_t'(T_RESET - 1);
  localparam bcnt_t LAST_BIT   = bcnt_t'(W - 1);
  localparam logic [2:0] LAST_IDX = 3'(NUM_LEDS - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t      state, next_state;
  logic        din_s1, din_s2, din_d;
  logic        rise, fall;
  cnt_t        high_cnt, low_cnt;
  logic [W-1:0] shift_reg;
  bcnt_t       bit_cnt;
  logic [2:0]  idx;

  logic shift_en, bit_val, glitch, overflow, do_latch;

  assign rise = din_s2 & ~din_d;
  assign fall = ~din_s2 & din_d;

  // Two-flop synchronizer plus a registered copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      din_s1 <= 1'b0;
      din_s2 <= 1'b0;
      din_d  <= 1'b0;
    end else begin
      din_s1 <= din;
      din_s2 <= din_s1;
      din_d  <= din_s2;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: rising edges start a pulse, falling edges end it, long lows latch
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (rise) next_state = HIGH;
      HIGH: if (fall) next_state = LOW;
      LOW: begin
        if (rise)          next_state = HIGH;
        else if (do_latch) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Decode strobes: bit shift, glitch, over-long pulse and latch detection
  always_comb begin
    shift_en = 1'b0;
    glitch   = 1'b0;
    overflow = 1'b0;
    do_latch = 1'b0;
    bit_val  = (high_cnt >= T_THRESH_C);
    if (state == HIGH) begin
      if (fall) begin
        if (high_cnt < T_MIN_C)        glitch   = 1'b1;
        else if (high_cnt <= T_MAX_C)  shift_en = 1'b1;
      end else if (high_cnt == T_MAX_C) begin
        overflow = 1'b1;
      end
    end else if (!rise && low_cnt == T_LATCH_C) begin
      do_latch = 1'b1;
    end
  end

  // High and low duration counters, each saturating so they never wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      high_cnt <= '0;
      low_cnt  <= '0;
    end else begin
      if (rise)
        high_cnt <= cnt_t'(1);
      else if (state == HIGH && high_cnt != T_SAT_C)
        high_cnt <= high_cnt + cnt_t'(1);

      if (fall)
        low_cnt <= cnt_t'(1);
      else if (state != HIGH && low_cnt != T_RESET_C)
        low_cnt <= low_cnt + cnt_t'(1);
    end
  end

  // Shift register, frame assembly, frame indexing and the sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      idx         <= '0;
      frame_data  <= '0;
      frame_index <= '0;
      frame_valid <= 1'b0;
      set_done    <= 1'b0;
      latch       <= 1'b0;
      bit_error   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      set_done    <= 1'b0;
      latch       <= 1'b0;
      if (shift_en) begin
        shift_reg <= {shift_reg[W-2:0], bit_val};
        if (bit_cnt == LAST_BIT) begin
          bit_cnt     <= '0;
          frame_data  <= {shift_reg[W-2:0], bit_val};
          frame_valid <= 1'b1;
          frame_index <= idx;
          set_done    <= (idx == LAST_IDX);
          idx         <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
        end else begin
          bit_cnt <= bit_cnt + bcnt_t'(1);
        end
      end
      if (glitch) bit_error <= 1'b1;
      if (overflow) begin
        bit_error <= 1'b1;
        bit_cnt   <= '0;
      end
      if (do_latch) begin
        latch   <= 1'b1;
        bit_cnt <= '0;
        idx     <= '0;
        if (bit_cnt != '0) bit_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_receiver.sv
// tb_frame_receiver: directed, table-driven bench for frame_receiver
module tb_frame_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic [23:0] frame_data;
  logic        frame_valid;
  logic [2:0]  frame_index;
  logic        set_done;
  logic        latch;
  logic        bit_error;

  int tests  = 0;
  int failed = 0;

  int          valid_cnt  = 0;
  int          latch_cnt  = 0;
  int          sd_cnt     = 0;
  int          orphan_sd  = 0;
  logic [23:0] last_data  = '0;
  logic [2:0]  last_idx   = '0;
  logic        last_sd    = 1'b0;

  typedef struct {
    logic [23:0] data;
    logic [2:0]  idx;
    logic        sd;
  } vec_t;

  vec_t vecs [8];

  frame_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_index(frame_index),
    .set_done   (set_done),
    .latch      (latch),
    .bit_error  (bit_error)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Capture output pulses on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (frame_valid) begin
      valid_cnt <= valid_cnt + 1;
      last_data <= frame_data;
      last_idx  <= frame_index;
      last_sd   <= set_done;
    end
    if (latch) latch_cnt <= latch_cnt + 1;
    if (set_done) sd_cnt <= sd_cnt + 1;
    if (set_done && !frame_valid) orphan_sd <= orphan_sd + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    din = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic sendLevel(input logic lvl, input int cycles);
    din = lvl;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b);
    if (b) begin
      sendLevel(1'b1, 40);
      sendLevel(1'b0, 22);
    end else begin
      sendLevel(1'b1, 20);
      sendLevel(1'b0, 42);
    end
  endtask

  task automatic sendBits(input logic [23:0] data, input int first, input int last);
    for (int i = first; i <= last; i++) sendBit(data[23 - i]);
  endtask

  task automatic applyStimulus(input logic [23:0] data);
    sendBits(data, 0, 23);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic checkFrame(input string name, input int base, input logic [23:0] data,
                            input logic [2:0] idx);
    checkOutput({name, ".valid_count"}, 32'(valid_cnt - base), 32'd1);
    checkOutput({name, ".data"}, {8'd0, last_data}, {8'd0, data});
    checkOutput({name, ".index"}, {29'd0, last_idx}, {29'd0, idx});
  endtask

  initial begin
    int base, lbase, sbase;
    vecs[0] = '{24'h000001, 3'd0, 1'b0};
    vecs[1] = '{24'h000002, 3'd1, 1'b0};
    vecs[2] = '{24'h000003, 3'd2, 1'b0};
    vecs[3] = '{24'h000004, 3'd3, 1'b0};
    vecs[4] = '{24'h000005, 3'd4, 1'b0};
    vecs[5] = '{24'h000006, 3'd5, 1'b0};
    vecs[6] = '{24'h000007, 3'd6, 1'b0};
    vecs[7] = '{24'h000008, 3'd7, 1'b1};

    // Reset state
    doReset();
    @(negedge clk);
    checkOutput("reset.frame_data", {8'd0, frame_data}, 32'd0);
    checkOutput("reset.frame_valid", {31'd0, frame_valid}, 32'd0);
    checkOutput("reset.frame_index", {29'd0, frame_index}, 32'd0);
    checkOutput("reset.set_done", {31'd0, set_done}, 32'd0);
    checkOutput("reset.latch", {31'd0, latch}, 32'd0);
    checkOutput("reset.bit_error", {31'd0, bit_error}, 32'd0);

    // Single frame 0xA5C31E
    base = valid_cnt;
    applyStimulus(24'hA5C31E);
    checkFrame("a5c31e", base, 24'hA5C31E, 3'd0);
    checkOutput("a5c31e.bit_error", {31'd0, bit_error}, 32'd0);

    // Full frame set from the table, then latch, then a fresh frame at index 0
    doReset();
    sbase = sd_cnt;
    for (int i = 0; i < 8; i++) begin
      base = valid_cnt;
      applyStimulus(vecs[i].data);
      checkFrame($sformatf("set[%0d]", i), base, vecs[i].data, vecs[i].idx);
      checkOutput($sformatf("set[%0d].set_done", i), {31'd0, last_sd}, {31'd0, vecs[i].sd});
    end
    checkOutput("set.set_done_count", 32'(sd_cnt - sbase), 32'd1);
    lbase = latch_cnt;
    base  = valid_cnt;
    sendLevel(1'b0, 2600);
    checkOutput("set.latch_count", 32'(latch_cnt - lbase), 32'd1);
    checkOutput("set.no_valid_in_latch", 32'(valid_cnt - base), 32'd0);
    checkOutput("set.bit_error", {31'd0, bit_error}, 32'd0);
    base = valid_cnt;
    applyStimulus(24'h123456);
    checkFrame("after_latch", base, 24'h123456, 3'd0);

    // Short glitch pulse inside a frame is flagged and not counted
    doReset();
    base = valid_cnt;
    sendBits(24'h5A5A5A, 0, 9);
    sendLevel(1'b1, 3);
    sendLevel(1'b0, 42);
    checkOutput("glitch.bit_error", {31'd0, bit_error}, 32'd1);
    sendBits(24'h5A5A5A, 10, 23);
    repeat (4) @(posedge clk);
    #1;
    checkFrame("glitch", base, 24'h5A5A5A, 3'd0);

    // Partial frame followed by latch
    doReset();
    base  = valid_cnt;
    lbase = latch_cnt;
    sendBits(24'hABCDEF, 0, 11);
    checkOutput("partial.bit_error_before", {31'd0, bit_error}, 32'd0);
    sendLevel(1'b0, 2600);
    checkOutput("partial.latch_count", 32'(latch_cnt - lbase), 32'd1);
    checkOutput("partial.bit_error", {31'd0, bit_error}, 32'd1);
    checkOutput("partial.no_valid", 32'(valid_cnt - base), 32'd0);
    base = valid_cnt;
    applyStimulus(24'h13579B);
    checkFrame("partial_next", base, 24'h13579B, 3'd0);

    // Line stuck high for 100 cycles
    doReset();
    base = valid_cnt;
    sendLevel(1'b1, 70);
    @(negedge clk);
    checkOutput("stuck.bit_error_early", {31'd0, bit_error}, 32'd0);
    @(posedge clk);
    #1;
    sendLevel(1'b1, 29);
    @(negedge clk);
    checkOutput("stuck.bit_error", {31'd0, bit_error}, 32'd1);
    @(posedge clk);
    #1;
    sendLevel(1'b0, 50);
    checkOutput("stuck.no_valid", 32'(valid_cnt - base), 32'd0);
    base = valid_cnt;
    applyStimulus(24'h0F0F0F);
    checkFrame("stuck_next", base, 24'h0F0F0F, 3'd0);

    // Reset mid-frame discards the partial frame
    doReset();
    sendBits(24'hC3C3C3, 0, 9);
    base = valid_cnt;
    doReset();
    @(negedge clk);
    checkOutput("midrst.frame_valid", {31'd0, frame_valid}, 32'd0);
    checkOutput("midrst.bit_error", {31'd0, bit_error}, 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(24'hFFFFFF);
    checkFrame("midrst", base, 24'hFFFFFF, 3'd0);
    checkOutput("midrst.bit_error_after", {31'd0, bit_error}, 32'd0);

    checkOutput("orphan_set_done", 32'(orphan_sd), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
